// File: rtl/beta_shift_seq.sv
// Issue-side sequencer for the iterative shifter: holds an op, drives the shifter enable
// for exactly shamt cycles, captures the result and presents it through an output register.
module beta_shift_seq #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [XLEN-1:0]  in_data_i,
    input  logic [4:0]       in_shamt_i,
    input  logic [1:0]       in_mode_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic [XLEN-1:0]  shu_opa_o,
    output logic [4:0]       shu_opb_o,
    output logic [1:0]       shu_mode_o,
    output logic             shu_en_o,
    input  logic [XLEN-1:0]  shu_result_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  out_data_o,
    output logic [TAG_W-1:0] out_tag_o,
    output logic             out_err_o
);

    // Mirrors the beta_pkg encoding; only the reserved code matters to the sequencer.
    localparam logic [1:0] ModeIllegal = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StCapture,
        StOut
    } state_e;

    state_e             state_q;
    logic [4:0]         cnt_q;
    logic [XLEN-1:0]    data_q;
    logic [4:0]         shamt_q;
    logic [1:0]         mode_q;
    logic [TAG_W-1:0]   tag_q;
    logic               out_valid_q;
    logic [XLEN-1:0]    out_data_q;
    logic [TAG_W-1:0]   out_tag_q;
    logic               out_err_q;

    logic accept;
    logic in_illegal;
    logic in_bypass;

    assign in_ready_o = (state_q == StIdle) | ((state_q == StOut) & out_ready_i);
    assign accept     = in_valid_i & in_ready_o & ~flush_i;
    assign in_illegal = (in_mode_i == ModeIllegal);
    // The shifter cannot do a zero-length shift, so those ops skip it entirely.
    assign in_bypass  = (in_shamt_i == 5'd0) | in_illegal;

    assign shu_opa_o   = data_q;
    assign shu_opb_o   = shamt_q;
    assign shu_mode_o  = mode_q;
    assign shu_en_o    = (state_q == StShift) & ~flush_i;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_tag_o   = out_tag_q;
    assign out_err_o   = out_err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            cnt_q       <= 5'd0;
            data_q      <= '0;
            shamt_q     <= 5'd0;
            mode_q      <= 2'b00;
            tag_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_err_q   <= 1'b0;
        end else if (flush_i) begin
            state_q     <= StIdle;
            cnt_q       <= 5'd0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: ;
                StShift: begin
                    cnt_q <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_q <= StCapture;
                    end
                end
                StCapture: begin
                    out_data_q  <= shu_result_i;
                    out_tag_q   <= tag_q;
                    out_err_q   <= 1'b0;
                    out_valid_q <= 1'b1;
                    state_q     <= StOut;
                end
                StOut: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            // A new op overrides the hand-off above when it lands in the same cycle.
            if (accept) begin
                data_q  <= in_data_i;
                shamt_q <= in_shamt_i;
                mode_q  <= in_mode_i;
                tag_q   <= in_tag_i;
                cnt_q   <= in_shamt_i;
                if (in_bypass) begin
                    state_q     <= StOut;
                    out_valid_q <= 1'b1;
                    out_data_q  <= in_data_i;
                    out_tag_q   <= in_tag_i;
                    out_err_q   <= in_illegal;
                end else begin
                    state_q     <= StShift;
                    out_valid_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_beta_shift_seq.sv
// Self-checking bench for beta_shift_seq: a behavioural iterative shifter sits on the shu_*
// side and results are compared against plain shift arithmetic.
module tb_beta_shift_seq;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready_o;
    logic [XLEN-1:0]  in_data;
    logic [4:0]       in_shamt;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic [XLEN-1:0]  shu_opa_o;
    logic [4:0]       shu_opb_o;
    logic [1:0]       shu_mode_o;
    logic             shu_en_o;
    logic [XLEN-1:0]  shu_result;
    logic             out_valid_o;
    logic             out_ready;
    logic [XLEN-1:0]  out_data_o;
    logic [TAG_W-1:0] out_tag_o;
    logic             out_err_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    beta_shift_seq #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready_o),
        .in_data_i    (in_data),
        .in_shamt_i   (in_shamt),
        .in_mode_i    (in_mode),
        .in_tag_i     (in_tag),
        .shu_opa_o    (shu_opa_o),
        .shu_opb_o    (shu_opb_o),
        .shu_mode_o   (shu_mode_o),
        .shu_en_o     (shu_en_o),
        .shu_result_i (shu_result),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data_o),
        .out_tag_o    (out_tag_o),
        .out_err_o    (out_err_o)
    );

    function automatic logic [31:0] ref_shift(logic [31:0] v, logic [1:0] m, int n);
        case (m)
            2'b00:   return v << n;
            2'b01:   return v >> n;
            2'b10:   return 32'($signed(v) >>> n);
            default: return v;
        endcase
    endfunction

    function automatic logic [31:0] ref_result(logic [31:0] v, logic [4:0] s, logic [1:0] m);
        if (m == 2'b11 || s == 5'd0) return v;
        return ref_shift(v, m, int'(s));
    endfunction

    // Iterative shifter: result reflects one more bit of shift per enabled cycle, restarts
    // whenever the enable drops.
    int          env_k;
    logic [31:0] env_acc;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            env_k   <= 0;
            env_acc <= '0;
        end else if (shu_en_o) begin
            env_k   <= env_k + 1;
            env_acc <= ref_shift(shu_opa_o, shu_mode_o, env_k + 1);
        end else begin
            env_k <= 0;
        end
    end
    assign shu_result = env_acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [31:0] d, input logic [4:0] s, input logic [1:0] m,
                            input logic [4:0] t);
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = s;
        in_mode  = m;
        in_tag   = t;
    endtask

    // Starts in the cycle after the accept edge; returns after the negedge of the valid cycle.
    task automatic await_res(input logic [31:0] d, input logic [4:0] s, input logic [1:0] m,
                             input logic [4:0] t, input logic [31:0] exp_d,
                             input logic exp_e);
        int  lat = 0;
        int  en  = 0;
        bit  seen = 0;
        bit  byp;
        byp = (s == 5'd0) || (m == 2'b11);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (shu_en_o) begin
                en++;
                check("opa_hold", shu_opa_o, d);
                check("opb_hold", 32'(shu_opb_o), 32'(s));
            end
            if (out_valid_o) begin
                lat  = c;
                seen = 1;
                break;
            end
            tick();
        end
        if (!seen) check("timeout", 32'd0, 32'd1);
        check("latency", lat, byp ? 32'd1 : 32'(s) + 32'd2);
        check("en_cycles", en, byp ? 32'd0 : 32'(s));
        check("out_data", out_data_o, exp_d);
        check("out_tag", 32'(out_tag_o), 32'(t));
        check("out_err", 32'(out_err_o), 32'(exp_e));
    endtask

    // Holds the result back for 'hold' cycles, then hands it off; ends at posedge+1.
    task automatic release_out(input int hold);
        logic [31:0] d0;
        d0 = out_data_o;
        for (int i = 0; i < hold; i++) begin
            check("stall_ready", 32'(in_ready_o), 32'd0);
            tick();
            @(negedge clk);
            check("stall_valid", 32'(out_valid_o), 32'd1);
            check("stall_data", out_data_o, d0);
        end
        out_ready = 1'b1;
        #1;
        check("out_in_ready", 32'(in_ready_o), 32'd1);
        tick();
        out_ready = 1'b0;
        check("valid_drop", 32'(out_valid_o), 32'd0);
    endtask

    task automatic do_op(input logic [31:0] d, input logic [4:0] s, input logic [1:0] m,
                         input logic [4:0] t, input logic [31:0] exp_d, input logic exp_e,
                         input int hold);
        drive_op(d, s, m, t);
        @(negedge clk);
        check("idle_ready", 32'(in_ready_o), 32'd1);
        tick();
        in_valid = 1'b0;
        await_res(d, s, m, t, exp_d, exp_e);
        release_out(hold);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [4:0]  s;
        logic [1:0]  m;
        logic [4:0]  t;
        int          sel;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_shamt = '0;
        in_mode = '0; in_tag = '0; out_ready = 1'b0;
        #12;
        check("rst_in_ready", 32'(in_ready_o), 32'd1);
        check("rst_out_valid", 32'(out_valid_o), 32'd0);
        check("rst_shu_en", 32'(shu_en_o), 32'd0);
        check("rst_out_data", out_data_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        do_op(32'h0000_0001, 5'd4, 2'b00, 5'd3, 32'h0000_0010, 1'b0, 0);
        do_op(32'h8000_0000, 5'd31, 2'b10, 5'd4, 32'hFFFF_FFFF, 1'b0, 0);
        do_op(32'h8000_0000, 5'd31, 2'b01, 5'd5, 32'h0000_0001, 1'b0, 0);
        do_op(32'hDEAD_BEEF, 5'd0, 2'b00, 5'd7, 32'hDEAD_BEEF, 1'b0, 0);
        do_op(32'h1234_5678, 5'd3, 2'b11, 5'd9, 32'h1234_5678, 1'b1, 1);
        do_op(32'hF000_000F, 5'd1, 2'b01, 5'd2, 32'h7800_0007, 1'b0, 0);

        // Writeback stalls 5 cycles, then hand-off and next accept share one edge.
        drive_op(32'h0000_0003, 5'd2, 2'b00, 5'd10);
        @(negedge clk);
        tick();
        in_valid = 1'b0;
        await_res(32'h0000_0003, 5'd2, 2'b00, 5'd10, 32'h0000_000C, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("bb_stall_ready", 32'(in_ready_o), 32'd0);
            tick();
            @(negedge clk);
            check("bb_stall_data", out_data_o, 32'h0000_000C);
        end
        out_ready = 1'b1;
        drive_op(32'h0000_0100, 5'd4, 2'b01, 5'd11);
        #1;
        check("bb_in_ready", 32'(in_ready_o), 32'd1);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        await_res(32'h0000_0100, 5'd4, 2'b01, 5'd11, 32'h0000_0010, 1'b0);
        release_out(0);

        // Flush in the third shift cycle of a 10-bit shift.
        drive_op(32'h0000_00FF, 5'd10, 2'b00, 5'd12);
        @(negedge clk);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        flush = 1'b1;
        @(negedge clk);
        check("flush_en", 32'(shu_en_o), 32'd0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("flush_idle_ready", 32'(in_ready_o), 32'd1);
        check("flush_idle_en", 32'(shu_en_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("flush_no_valid", 32'(out_valid_o), 32'd0);
            tick();
            @(negedge clk);
        end
        tick();
        do_op(32'h0000_0001, 5'd1, 2'b00, 5'd13, 32'h0000_0002, 1'b0, 0);

        // Flush while a result waits: the result is dropped and no op is taken.
        drive_op(32'h0000_0005, 5'd0, 2'b00, 5'd14);
        @(negedge clk);
        tick();
        in_valid = 1'b0;
        await_res(32'h0000_0005, 5'd0, 2'b00, 5'd14, 32'h0000_0005, 1'b0);
        flush     = 1'b1;
        out_ready = 1'b1;
        drive_op(32'h0000_0001, 5'd0, 2'b00, 5'd15);
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 32'(out_valid_o), 32'd0);
        check("flush_no_accept", 32'(in_ready_o), 32'd1);
        tick();

        // Asynchronous reset in the middle of a shift.
        drive_op(32'hCAFE_F00D, 5'd20, 2'b01, 5'd16);
        @(negedge clk);
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_in_ready", 32'(in_ready_o), 32'd1);
        check("arst_en", 32'(shu_en_o), 32'd0);
        check("arst_opa", shu_opa_o, 32'd0);
        check("arst_opb", 32'(shu_opb_o), 32'd0);
        check("arst_mode", 32'(shu_mode_o), 32'd0);
        check("arst_valid", 32'(out_valid_o), 32'd0);
        check("arst_data", out_data_o, 32'd0);
        check("arst_tag", 32'(out_tag_o), 32'd0);
        check("arst_err", 32'(out_err_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        do_op(32'h0000_0008, 5'd3, 2'b01, 5'd17, 32'h0000_0001, 1'b0, 0);

        for (int n = 0; n < 40; n++) begin
            d   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0)      s = 5'd0;
            else if (sel == 1) s = 5'd31;
            else               s = 5'($urandom_range(1, 31));
            m = 2'($urandom_range(0, 3));
            t = 5'($urandom);
            do_op(d, s, m, t, ref_result(d, s, m), m == 2'b11, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
